// File: rtl/pacman_mover.sv
// pacman_mover: steps Pac-Man one tile per game_tick, trying the requested
// direction first and falling back to the current one via 1-cycle wall lookups.
module pacman_mover #(
  parameter int GRID_W  = 28,
  parameter int GRID_H  = 31,
  parameter int START_X = 13,
  parameter int START_Y = 23
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       game_tick,
  input  logic [1:0] dir_req,
  input  logic       dir_req_valid,
  output logic       wall_rd,
  output logic [4:0] wall_x,
  output logic [4:0] wall_y,
  input  logic       wall_bit,
  output logic [4:0] pos_x,
  output logic [4:0] pos_y,
  output logic [1:0] dir_cur,
  output logic       moved,
  output logic       busy
);
  localparam logic [4:0] XMAX = 5'(GRID_W - 1);
  localparam logic [4:0] YMAX = 5'(GRID_H - 1);
  typedef enum logic [2:0] {IDLE, Q1, W1, Q2, W2, COMMIT} state_t;
  state_t state_q, state_d;
  logic [4:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d, wall_x_q, wall_y_q;
  logic [1:0] dir_cur_q, dir_cur_d, pending_q, pending_d, snap_q, snap_d, chosen_q, chosen_d;
  logic       moved_q, moved_d;
  logic [10:0] nt_snap, nt_cur, nt_chosen;
  // returns {in_range, x, y}; x wraps through the tunnel, y never wraps
  function automatic logic [10:0] nt(input logic [1:0] d, input logic [4:0] x, input logic [4:0] y);
    logic ok;
    logic [4:0] nx, ny;
    ok = 1'b1;
    nx = x;
    ny = y;
    case (d)
      2'd0: nx = (x == XMAX) ? 5'd0 : x + 5'd1;
      2'd1: begin ok = (y != 5'd0); ny = y - 5'd1; end
      2'd2: nx = (x == 5'd0) ? XMAX : x - 5'd1;
      default: begin ok = (y != YMAX); ny = y + 5'd1; end
    endcase
    return {ok, nx, ny};
  endfunction
  assign nt_snap   = nt(snap_q, pos_x_q, pos_y_q);
  assign nt_cur    = nt(dir_cur_q, pos_x_q, pos_y_q);
  assign nt_chosen = nt(chosen_q, pos_x_q, pos_y_q);
  always_comb begin
    state_d   = state_q;
    pending_d = dir_req_valid ? dir_req : pending_q;
    snap_d    = snap_q;
    chosen_d  = chosen_q;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    dir_cur_d = dir_cur_q;
    moved_d   = 1'b0;
    wall_rd   = 1'b0;
    wall_x    = wall_x_q;
    wall_y    = wall_y_q;
    case (state_q)
      IDLE: if (game_tick) begin
        state_d = Q1;
        snap_d  = pending_d;
      end
      Q1: if (nt_snap[10]) begin
        wall_rd = 1'b1;
        wall_x  = nt_snap[9:5];
        wall_y  = nt_snap[4:0];
        state_d = W1;
      end else state_d = Q2;
      W1: if (!wall_bit) begin
        chosen_d = snap_q;
        state_d  = COMMIT;
      end else state_d = Q2;
      Q2: if (snap_q == dir_cur_q || !nt_cur[10]) state_d = IDLE;
      else begin
        wall_rd = 1'b1;
        wall_x  = nt_cur[9:5];
        wall_y  = nt_cur[4:0];
        state_d = W2;
      end
      W2: if (!wall_bit) begin
        chosen_d = dir_cur_q;
        state_d  = COMMIT;
      end else state_d = IDLE;
      COMMIT: begin
        pos_x_d   = nt_chosen[9:5];
        pos_y_d   = nt_chosen[4:0];
        dir_cur_d = chosen_q;
        moved_d   = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      pos_x_q   <= 5'(START_X);
      pos_y_q   <= 5'(START_Y);
      dir_cur_q <= 2'd2;
      pending_q <= 2'd2;
      snap_q    <= 2'd2;
      chosen_q  <= 2'd2;
      wall_x_q  <= 5'd0;
      wall_y_q  <= 5'd0;
      moved_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      dir_cur_q <= dir_cur_d;
      pending_q <= pending_d;
      snap_q    <= snap_d;
      chosen_q  <= chosen_d;
      wall_x_q  <= wall_x;
      wall_y_q  <= wall_y;
      moved_q   <= moved_d;
    end
  end
  assign pos_x   = pos_x_q;
  assign pos_y   = pos_y_q;
  assign dir_cur = dir_cur_q;
  assign moved   = moved_q;
  assign busy    = (state_q != IDLE);
endmodule

// File: tb/tb_pacman_mover.sv
// tb_pacman_mover: directed cycle-accurate checks of pacman_mover stepping,
// tunnel wrap, fallback, blocked steps, ignored ticks and async reset.
module tb_pacman_mover;
  logic       Clk = 1'b0, Reset = 1'b1, game_tick = 1'b0, dir_req_valid = 1'b0, wall_bit = 1'b0;
  logic [1:0] dir_req = 2'd0;
  logic       wall_rd, moved, busy;
  logic [4:0] wall_x, wall_y, pos_x, pos_y;
  logic [1:0] dir_cur;
  int total = 0, bad = 0, cnt = 0;
  pacman_mover dut (
    .Clk(Clk), .Reset(Reset), .game_tick(game_tick), .dir_req(dir_req),
    .dir_req_valid(dir_req_valid), .wall_rd(wall_rd), .wall_x(wall_x), .wall_y(wall_y),
    .wall_bit(wall_bit), .pos_x(pos_x), .pos_y(pos_y), .dir_cur(dir_cur),
    .moved(moved), .busy(busy)
  );
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic cyc;
    @(posedge Clk);
    #1;
  endtask
  // full free step: request coincident with tick, no walls
  task automatic step(input logic [1:0] d);
    dir_req = d; dir_req_valid = 1'b1; game_tick = 1'b1; wall_bit = 1'b0;
    cyc;
    dir_req_valid = 1'b0; game_tick = 1'b0;
    repeat (5) cyc;
  endtask
  initial begin
    repeat (2) cyc;
    chk("rst_held_px", 32'(pos_x), 13);
    Reset = 1'b0;
    cyc;
    chk("rst_px", 32'(pos_x), 13);
    chk("rst_py", 32'(pos_y), 23);
    chk("rst_dir", 32'(dir_cur), 2);
    chk("rst_rd", 32'(wall_rd), 0);
    chk("rst_wx", 32'(wall_x), 0);
    chk("rst_wy", 32'(wall_y), 0);
    chk("rst_moved", 32'(moved), 0);
    chk("rst_busy", 32'(busy), 0);
    // free step using pending=2
    game_tick = 1'b1; wall_bit = 1'b0;
    cyc;
    game_tick = 1'b0;
    chk("t1_rd_c1", 32'(wall_rd), 1);
    chk("t1_wx", 32'(wall_x), 12);
    chk("t1_wy", 32'(wall_y), 23);
    chk("t1_busy_c1", 32'(busy), 1);
    cyc;
    chk("t1_rd_c2", 32'(wall_rd), 0);
    cyc;
    chk("t1_moved_c3", 32'(moved), 0);
    chk("t1_px_c3", 32'(pos_x), 13);
    cyc;
    chk("t1_px_c4", 32'(pos_x), 12);
    chk("t1_py_c4", 32'(pos_y), 23);
    chk("t1_dir_c4", 32'(dir_cur), 2);
    chk("t1_moved_c4", 32'(moved), 1);
    cyc;
    chk("t1_moved_c5", 32'(moved), 0);
    chk("t1_busy_c5", 32'(busy), 0);
    chk("t1_wx_hold", 32'(wall_x), 12);
    // fallback to current direction
    Reset = 1'b1; cyc; Reset = 1'b0; cyc;
    dir_req = 2'd1; dir_req_valid = 1'b1; cyc; dir_req_valid = 1'b0;
    game_tick = 1'b1; wall_bit = 1'b1;
    cyc;
    game_tick = 1'b0;
    chk("t2_rd_c1", 32'(wall_rd), 1);
    chk("t2_wx1", 32'(wall_x), 13);
    chk("t2_wy1", 32'(wall_y), 22);
    cyc;
    chk("t2_rd_c2", 32'(wall_rd), 0);
    cyc;
    chk("t2_rd_c3", 32'(wall_rd), 1);
    chk("t2_wx2", 32'(wall_x), 12);
    chk("t2_wy2", 32'(wall_y), 23);
    wall_bit = 1'b0;
    cyc;
    cyc;
    chk("t2_px_c5", 32'(pos_x), 13);
    chk("t2_moved_c5", 32'(moved), 0);
    cyc;
    chk("t2_px_c6", 32'(pos_x), 12);
    chk("t2_py_c6", 32'(pos_y), 23);
    chk("t2_dir_c6", 32'(dir_cur), 2);
    chk("t2_moved_c6", 32'(moved), 1);
    cyc;
    // walk to (0,14), then tunnel both ways
    repeat (12) step(2'd2);
    repeat (9) step(2'd1);
    chk("t3_walk_px", 32'(pos_x), 0);
    chk("t3_walk_py", 32'(pos_y), 14);
    dir_req = 2'd2; dir_req_valid = 1'b1; game_tick = 1'b1; wall_bit = 1'b0;
    cyc;
    dir_req_valid = 1'b0; game_tick = 1'b0;
    chk("t3_wx_left", 32'(wall_x), 27);
    chk("t3_wy_left", 32'(wall_y), 14);
    repeat (3) cyc;
    chk("t3_px_left", 32'(pos_x), 27);
    chk("t3_dir_left", 32'(dir_cur), 2);
    cyc;
    dir_req = 2'd0; dir_req_valid = 1'b1; game_tick = 1'b1;
    cyc;
    dir_req_valid = 1'b0; game_tick = 1'b0;
    chk("t3_wx_right", 32'(wall_x), 0);
    repeat (3) cyc;
    chk("t3_px_right", 32'(pos_x), 0);
    chk("t3_py_right", 32'(pos_y), 14);
    cyc;
    // request coincident with tick overrides pending
    dir_req = 2'd2; dir_req_valid = 1'b1; cyc; dir_req_valid = 1'b0;
    dir_req = 2'd3; dir_req_valid = 1'b1; game_tick = 1'b1;
    cyc;
    dir_req_valid = 1'b0; game_tick = 1'b0;
    chk("t4_wx", 32'(wall_x), 0);
    chk("t4_wy", 32'(wall_y), 15);
    repeat (3) cyc;
    chk("t4_py", 32'(pos_y), 15);
    chk("t4_dir", 32'(dir_cur), 3);
    cyc;
    // top edge: no query, no move
    repeat (15) step(2'd1);
    chk("t5_walk_py", 32'(pos_y), 0);
    dir_req = 2'd1; dir_req_valid = 1'b1; game_tick = 1'b1;
    cyc;
    dir_req_valid = 1'b0; game_tick = 1'b0;
    cnt = int'(wall_rd) + int'(moved);
    cyc;
    cnt += int'(wall_rd) + int'(moved);
    chk("t5_busy_c2", 32'(busy), 1);
    cyc;
    cnt += int'(wall_rd) + int'(moved);
    chk("t5_busy_c3", 32'(busy), 0);
    cyc;
    cnt += int'(wall_rd) + int'(moved);
    chk("t5_no_rd_move", 32'(cnt), 0);
    chk("t5_py", 32'(pos_y), 0);
    // extra tick while busy is ignored
    dir_req = 2'd0; dir_req_valid = 1'b1; game_tick = 1'b1; wall_bit = 1'b0;
    cyc;
    dir_req_valid = 1'b0; game_tick = 1'b0;
    cnt = int'(moved);
    cyc;
    game_tick = 1'b1;
    cnt += int'(moved);
    cyc;
    game_tick = 1'b0;
    cnt += int'(moved);
    repeat (8) begin cyc; cnt += int'(moved); end
    chk("t6_one_move", 32'(cnt), 1);
    chk("t6_px", 32'(pos_x), 1);
    chk("t6_py", 32'(pos_y), 0);
    chk("t6_dir", 32'(dir_cur), 0);
    // async reset mid-step
    dir_req = 2'd0; dir_req_valid = 1'b1; game_tick = 1'b1;
    cyc;
    dir_req_valid = 1'b0; game_tick = 1'b0;
    cyc;
    Reset = 1'b1;
    #1;
    chk("t7_px", 32'(pos_x), 13);
    chk("t7_py", 32'(pos_y), 23);
    chk("t7_dir", 32'(dir_cur), 2);
    chk("t7_rd", 32'(wall_rd), 0);
    chk("t7_busy", 32'(busy), 0);
    cyc;
    Reset = 1'b0;
    cnt = 0;
    repeat (6) begin cyc; cnt += int'(moved); end
    chk("t7_no_move", 32'(cnt), 0);
    chk("t7_px_after", 32'(pos_x), 13);
    // both directions blocked
    dir_req = 2'd1; dir_req_valid = 1'b1; game_tick = 1'b1; wall_bit = 1'b1;
    cyc;
    dir_req_valid = 1'b0; game_tick = 1'b0;
    cnt = int'(wall_rd);
    repeat (3) begin cyc; cnt += int'(wall_rd); end
    chk("t8_busy_c4", 32'(busy), 1);
    cyc;
    chk("t8_busy_c5", 32'(busy), 0);
    chk("t8_two_rd", 32'(cnt), 2);
    chk("t8_px", 32'(pos_x), 13);
    chk("t8_py", 32'(pos_y), 23);
    chk("t8_dir", 32'(dir_cur), 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
